fetch_unit: RTL

- Instruction-fetch stage that owns the program counter and drives the word address into the combinational instruction memory.
- Captures the returned 32-bit instruction together with its PC into a 2-entry buffer.
- Presents buffered instructions to decode over a valid/ready handshake.
- Handles branch/jump redirects with a buffer flush, and flags fetches beyond the instruction memory range.

---
 rtl/fetch_unit.sv | 134 +++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction-fetch stage. Owns the program counter, drives the word address
//   into a combinational instruction memory, and captures each returned word
//   with its PC into a 2-entry FIFO. The FIFO head is offered to decode over a
//   valid/ready handshake. A redirect flushes the FIFO and reloads the PC. A
//   fetch attempt beyond the memory range sets a sticky fault.
//
//   Optional performance counters are compiled in when FETCH_PERF_EN is defined.
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   synchronous active-high reset
//   pc            out  byte address to instruction memory (word = pc[31:2])
//   instr_in      in   instruction word for the current pc
//   redirect      in   taken branch/jump pulse
//   redirect_pc   in   redirect target byte address (low two bits dropped)
//   out_valid     out  FIFO head holds a valid instruction
//   out_ready     in   decode accepts the head this cycle
//   out_instr     out  instruction at FIFO head
//   out_pc        out  PC of out_instr
//   out_pc_plus4  out  out_pc + 4
//   fault         out  sticky out-of-range fetch flag
//   perf_fetched  out  (FETCH_PERF_EN) number of pushes
//   perf_stall    out  (FETCH_PERF_EN) cycles stalled on a full FIFO

module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 76
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc,
    input  logic [31:0] instr_in,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4,
    output logic        fault
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    logic [31:0] buf_instr [2];
    logic [31:0] buf_pc    [2];
    logic [31:0] buf_pc4   [2];
    logic        head;
    logic        tail;
    logic [1:0]  count;

    logic        in_range;
    logic        full;
    logic        pop;
    logic        push;

    // Target low bits are discarded on redirect.
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = &{1'b0, redirect_pc[1:0]};

    assign in_range = ({2'b00, pc[31:2]} < IMEM_WORDS);
    assign full     = (count == 2'd2);
    assign pop      = out_valid & out_ready;
    assign push     = ~redirect & ~fault & in_range & (~full | pop);

    assign out_valid    = (count != 2'd0);
    assign out_instr    = buf_instr[head];
    assign out_pc       = buf_pc[head];
    // Stored at push time so the head output is a pure register read.
    assign out_pc_plus4 = buf_pc4[head];

    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= RESET_PC;
            count <= 2'd0;
            head  <= 1'b0;
            tail  <= 1'b0;
            fault <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                buf_instr[i] <= 32'd0;
                buf_pc[i]    <= 32'd0;
                buf_pc4[i]   <= 32'd0;
            end
        end else if (redirect) begin
            // Flush wins over any concurrent pop; fault is left untouched.
            count <= 2'd0;
            head  <= 1'b0;
            tail  <= 1'b0;
            pc    <= {redirect_pc[31:2], 2'b00};
        end else begin
            // The fault records the attempt even while the FIFO is full, so
            // it can coexist with a full buffer that is still draining.
            if (!in_range) begin
                fault <= 1'b1;
            end
            if (push) begin
                buf_instr[tail] <= instr_in;
                buf_pc[tail]    <= pc;
                buf_pc4[tail]   <= pc + 32'd4;
                tail            <= ~tail;
                pc              <= pc + 32'd4;
            end
            if (pop) begin
                head <= ~head;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched <= 32'd0;
            perf_stall   <= 32'd0;
        end else begin
            if (push) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (full && !pop && !redirect && !fault) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule
